hazard_forward_ctrl: RTL
========================

// Module: hazard_forward_ctrl
// PURPOSE
//  Produces the 4-bit forwarding code consumed by the EX-stage operand selector.
//  Also produces the stall and bubble controls for the 5-stage MIPS pipeline.
//  Sits beside the ID/EX register and sees decoded source/destination fields in ID.
//  Keeps its own EX/MEM destination shadow pipeline.
//  Decides the next cycle's forwarding per instruction, registered into TypeE.
// PARAMETERS
//  REG_AW   5   register-address width
//  CNT_W    16  statistics counter width (FWD_STATS_EN only)
// PORTS
//  Clk         in   1       pipeline clock, rising edge
//  Rst_n       in   1       asynchronous, active-low reset
//  ValidD      in   1       ID holds a real instruction
//  RsD, RtD    in   REG_AW  ID source register numbers
//  UseRsD      in   1       ID instruction reads Rs
//  UseRtD      in   1       ID instruction reads Rt
//  WriteRegD   in   REG_AW  ID destination register
//  RegWriteD   in   1       ID instruction writes WriteRegD
//  MemToRegD   in   1       ID instruction is a load
//  FlushD      in   1       branch flush: ID instruction is squashed into a bubble
//  TypeE       out  4       forwarding code for the instruction now in EX
//  StallF      out  1       hold PC
//  StallD      out  1       hold IF/ID
//  BubbleE     out  1       load a NOP into ID/EX
//  StallCnt    out  CNT_W   stall cycles, saturating (FWD_STATS_EN only)
//  FwdCnt      out  CNT_W   non-zero TypeE cycles, saturating (FWD_STATS_EN only)
// BEHAVIOUR
//  TypeE codes
//   0: no forwarding
//   1: SrcA from ALUOutM
//   2: SrcB from ALUOutM
//   5: SrcA from ALUOutW
//   6: SrcB from ALUOutW
//   7: SrcA from ReadDataW
//   8: SrcB from ReadDataW
//   Never drive codes 3, 4 or 9..15.
//  Shadow pipeline
//   Stage E holds {WriteReg, RegWrite, MemToReg}; stage M holds the same.
//   Every cycle E shifts into M.
//   D shifts into E only when no stall and no flush; otherwise E receives a bubble (RegWrite=0).
//  Hazard match
//   Operand X (Rs or Rt) of the ID instruction matches a stage S when all hold:
//   UseX, ValidD, S.RegWrite, S.WriteReg==X, X!=0.
//   The E stage has priority over M: the nearest producer wins.
//  Per-operand need for the next cycle
//   E match, non-load  -> MEM forward (code 1 or 2).
//   E match, load      -> unforwardable: stall.
//   M match, non-load  -> ALUOutW forward (code 5 or 6).
//   M match, load      -> ReadDataW forward (code 7 or 8).
//   Older producers need nothing: the register file writes before it is read.
//  Stall condition (combinational)
//   Stall = any unforwardable need, OR both operands need forwarding.
//   This includes Rs==Rt with the same producer: the selector takes one code only.
//   On stall: StallF=StallD=BubbleE=1 and TypeE is loaded with 0.
//   Stalling repeats each cycle until the condition clears (at most 2 cycles).
//  TypeE is a register, updated every cycle
//   stall or FlushD -> 0; otherwise the single needed code, or 0.
//  FlushD with a concurrent hazard: the flush wins.
//   BubbleE=1, no stall, TypeE=0.
//  ValidD=0: no hazard; the bubble propagates.
//  Reset (async): E, M, TypeE, StallCnt and FwdCnt all go to 0.
//   StallF/StallD/BubbleE evaluate to 0 while in reset.
//  Latency: decision in ID (cycle n); TypeE is valid for that instruction in EX (cycle n+1).
// CONFIGURATION
//  FWD_STATS_EN defined
//   StallCnt increments on every stall cycle, saturating at all-ones.
//   FwdCnt increments on every cycle with TypeE!=0, saturating at all-ones.
//  FWD_STATS_EN undefined
//   The counters and the StallCnt/FwdCnt ports are absent.
//   All other behaviour is identical.
// STRUCTURE
//  Shared package file (mips_defs.vh) holds:
//   FWD_* localparams for codes 0, 1, 2, 5, 6, 7, 8
//   REG_ZERO
//   the pipe-entry field widths
//  One sub-module, hazard_shadow_pipe, holds the E/M destination registers with bubble insertion.
//  Match, priority and stall logic stays in the top.
// TESTING
//  1. add $3 in EX; ID reads Rs=$3 (R-type) -> no stall, next cycle TypeE=1.
//  2. lw $4 in EX; ID add reads Rt=$4
//     -> StallF/D=1 and BubbleE=1 for 1 cycle (TypeE=0), then TypeE=8.
//  3. add $5 in EX, sub $6 in M; ID reads Rs=$5, Rt=$6
//     -> 1 stall cycle, then TypeE=5.
//  4. add $7 in EX; ID reads Rs=Rt=$7 -> 2 stall cycles, then TypeE=0.
//  5. Producer writes $0; ID reads $0 -> no stall, TypeE=0.
//     FlushD=1 with the case-2 hazard -> BubbleE=1, no stall, TypeE=0.
//  6. Rst_n low mid-stall -> TypeE=0 and stalls 0 immediately.
//     With FWD_STATS_EN: StallCnt=0, then counts 1 after one load-use.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: forwarding codes,
// the hardwired-zero register number and the shadow-pipe entry layout.
package hazard_forward_ctrl_pkg;

  localparam int TYPE_W = 4;

  // EX-stage operand selector codes; 3, 4 and 9..15 are never produced.
  localparam logic [TYPE_W-1:0] FWD_NONE   = 4'd0;
  localparam logic [TYPE_W-1:0] FWD_ALUM_A = 4'd1;  // SrcA <- ALUOutM
  localparam logic [TYPE_W-1:0] FWD_ALUM_B = 4'd2;  // SrcB <- ALUOutM
  localparam logic [TYPE_W-1:0] FWD_ALUW_A = 4'd5;  // SrcA <- ALUOutW
  localparam logic [TYPE_W-1:0] FWD_ALUW_B = 4'd6;  // SrcB <- ALUOutW
  localparam logic [TYPE_W-1:0] FWD_RDW_A  = 4'd7;  // SrcA <- ReadDataW
  localparam logic [TYPE_W-1:0] FWD_RDW_B  = 4'd8;  // SrcB <- ReadDataW

  // $0 is hardwired to zero and never creates a dependency.
  localparam int REG_ZERO = 0;

  // Control half of a shadow-pipe entry; the destination field is REG_AW wide.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } pipe_ctrl_t;

  // Only one operand may need forwarding at a time, so return whichever is set.
  function automatic logic [TYPE_W-1:0] pick_code(input logic [TYPE_W-1:0] a,
                                                  input logic [TYPE_W-1:0] b);
    return (a != FWD_NONE) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the EX and MEM destination fields. E loads the ID entry when
// the pipe advances, otherwise a bubble; M always takes E.
module hazard_shadow_pipe
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic [REG_AW-1:0] write_reg_d,
  input  pipe_ctrl_t        ctrl_d,
  output logic [REG_AW-1:0] write_reg_e,
  output pipe_ctrl_t        ctrl_e,
  output logic [REG_AW-1:0] write_reg_m,
  output pipe_ctrl_t        ctrl_m
);

  // Advance E into M every cycle; fill E from ID or with a bubble.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg_e <= '0;
      ctrl_e      <= '0;
      write_reg_m <= '0;
      ctrl_m      <= '0;
    end else begin
      write_reg_m <= write_reg_e;
      ctrl_m      <= ctrl_e;
      if (shift_en) begin
        write_reg_e <= write_reg_d;
        ctrl_e      <= ctrl_d;
      end else begin
        write_reg_e <= '0;
        ctrl_e      <= '0;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline.
// Decides in ID, registers the forwarding code into TypeE for the EX cycle.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
`ifdef FWD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ValidD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic              UseRsD,
  input  logic              UseRtD,
  input  logic [REG_AW-1:0] WriteRegD,
  input  logic              RegWriteD,
  input  logic              MemToRegD,
  input  logic              FlushD,
  output logic [TYPE_W-1:0] TypeE,
  output logic              StallF,
  output logic              StallD,
  output logic              BubbleE
`ifdef FWD_STATS_EN
  , output logic [CNT_W-1:0] StallCnt
  , output logic [CNT_W-1:0] FwdCnt
`endif
);

  logic [REG_AW-1:0] write_reg_e, write_reg_m;
  pipe_ctrl_t        ctrl_d, ctrl_e, ctrl_m;
  logic              rs_e, rs_m, rt_e, rt_m;
  logic              rs_unfwd, rt_unfwd;
  logic [TYPE_W-1:0] rs_code, rt_code, type_next;
  logic              hazard_stall, stall, shift_en;

  // An invalid ID slot enters the shadow pipe as a bubble.
  assign ctrl_d.reg_write  = RegWriteD & ValidD;
  assign ctrl_d.mem_to_reg = MemToRegD & ValidD;

  hazard_shadow_pipe #(.REG_AW(REG_AW)) u_shadow (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .shift_en    (shift_en),
    .write_reg_d (WriteRegD),
    .ctrl_d      (ctrl_d),
    .write_reg_e (write_reg_e),
    .ctrl_e      (ctrl_e),
    .write_reg_m (write_reg_m),
    .ctrl_m      (ctrl_m)
  );

  // Source-versus-producer matches; $0 and unused operands never match.
  assign rs_e = ValidD & UseRsD & ctrl_e.reg_write & (write_reg_e == RsD)
              & (RsD != REG_AW'(REG_ZERO));
  assign rs_m = ValidD & UseRsD & ctrl_m.reg_write & (write_reg_m == RsD)
              & (RsD != REG_AW'(REG_ZERO));
  assign rt_e = ValidD & UseRtD & ctrl_e.reg_write & (write_reg_e == RtD)
              & (RtD != REG_AW'(REG_ZERO));
  assign rt_m = ValidD & UseRtD & ctrl_m.reg_write & (write_reg_m == RtD)
              & (RtD != REG_AW'(REG_ZERO));

  // Per-operand need for next cycle; the nearer (E) producer takes priority.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rs_code  = FWD_NONE;
    rt_code  = FWD_NONE;
    rs_unfwd = 1'b0;
    rt_unfwd = 1'b0;
    if (rs_e) begin
      if (ctrl_e.mem_to_reg) rs_unfwd = 1'b1;
      else                   rs_code  = FWD_ALUM_A;
    end else if (rs_m) begin
      rs_code = ctrl_m.mem_to_reg ? FWD_RDW_A : FWD_ALUW_A;
    end
    if (rt_e) begin
      if (ctrl_e.mem_to_reg) rt_unfwd = 1'b1;
      else                   rt_code  = FWD_ALUM_B;
    end else if (rt_m) begin
      rt_code = ctrl_m.mem_to_reg ? FWD_RDW_B : FWD_ALUW_B;
    end
  end

  // The selector takes a single code, so two forwarding needs also stall.
  assign hazard_stall = rs_unfwd | rt_unfwd
                      | ((rs_code != FWD_NONE) & (rt_code != FWD_NONE));
  assign stall        = hazard_stall & ~FlushD;   // a flush squashes the consumer
  assign shift_en     = ~stall & ~FlushD;
  assign type_next    = (stall | FlushD) ? FWD_NONE : pick_code(rs_code, rt_code);

  assign StallF  = Rst_n & stall;
  assign StallD  = Rst_n & stall;
  assign BubbleE = Rst_n & (stall | FlushD);

  // Forwarding code register, valid while the instruction sits in EX.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) TypeE <= FWD_NONE;
    else        TypeE <= type_next;
  end

`ifdef FWD_STATS_EN
  // Saturating counters of stall cycles and forwarding cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCnt <= '0;
      FwdCnt   <= '0;
    end else begin
      if (stall && (StallCnt != '1))            StallCnt <= StallCnt + 1'b1;
      if ((TypeE != FWD_NONE) && (FwdCnt != '1)) FwdCnt  <= FwdCnt + 1'b1;
    end
  end
`endif

endmodule
